mul_acc_stage: RTL
==================

# mul_acc_stage

Frame accumulator directly downstream of the signed/unsigned multiplier. Consumes a stream of 2n-bit products over a valid/ready handshake, sums a programmed number of them into a saturating accumulator, and presents the total over a second valid/ready handshake. The signed/unsigned mode is latched per frame and matches the multiplier's `signed_mul` setting.

## Interface
- `n`, 8, multiplier operand width; products are 2n bits
- `len_w`, 4, width of the frame-length field; at most 2^len_w − 1 products per frame
- `acc_w`, 2*n+2, accumulator width; must be ≥ 2n+1

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle frame request; sampled only in IDLE
- `frame_len`  in  len_w  number of products in the frame; sampled with `start`
- `signed_mul`  in  1  frame mode, 1 = signed, 0 = unsigned; sampled with `start`
- `prod_valid`  in  1  product available
- `prod_ready`  out  1  stage accepts a product
- `prod`  in  2n  product from the multiplier
- `acc_valid`  out  1  result available
- `acc_ready`  in  1  consumer takes the result
- `acc`  out  acc_w  frame total
- `acc_sat`  out  1  sticky flag: saturation occurred in this frame
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCUM, OUTPUT.
- **IDLE**
  - `prod_ready` = 0.
  - `start` with nonzero `frame_len`: clear `acc`, clear `acc_sat`, load the counter with `frame_len`, latch the mode, go to ACCUM.
  - `start` with `frame_len` = 0: clear `acc`, clear `acc_sat`, go directly to OUTPUT.
- **ACCUM**
  - `prod_ready` = 1. A product is accepted when `prod_valid && prod_ready`.
  - On each accepted product:
    - Extend `prod` to acc_w bits: sign-extend in signed mode, zero-extend in unsigned mode.
    - Add it to `acc` in acc_w+1 bits and saturate.
    - Decrement the counter.
  - Accepting a product while the counter is 1 moves the FSM to OUTPUT.
- **OUTPUT**
  - `acc_valid` = 1. `acc` and `acc_sat` are held stable until `acc_ready` is high.
  - When `acc_valid && acc_ready`, go to IDLE.
- **Saturation, signed mode:** overflow occurs when both addends have the same sign and the sum's sign differs. A positive overflow clamps to 2^(acc_w−1)−1; a negative overflow clamps to −2^(acc_w−1).
- **Saturation, unsigned mode:** a carry out of bit acc_w−1 clamps to 2^acc_w−1.
- Once the accumulator has saturated, later additions still apply. A subsequent opposite-sign product can move the value back off the rail. `acc_sat` stays 1 until the next frame clears it.
- `start` is ignored while `busy` is high; there is no queuing.
- `prod_valid` in IDLE or OUTPUT is not accepted; the producer holds the product.

## Timing
- **Reset values:** state = IDLE; `acc` = 0; `acc_sat` = 0; counter = 0; `prod_ready` = 0; `acc_valid` = 0; `busy` = 0.
- **Asynchronous reset mid-frame:** the partial sum is discarded and the stage returns to IDLE immediately. No result is emitted.
- **Throughput:** one product per cycle while in ACCUM.
- **Latency:**
  - `busy` and `prod_ready` rise in the cycle after `start`.
  - `acc_valid` rises in the cycle after the last product is accepted.
  - For a zero-length frame, `acc_valid` rises in the cycle after `start`.
- **Back-to-back frames:** the earliest next `start` is the cycle after the result handshake, which gives one IDLE cycle between frames.
- **Output decoding:** all handshake outputs are decoded from registered state only, with no combinational path from inputs.

## Structure
- **Package `mul_acc_pkg`:** holds the state enum typedef (IDLE, ACCUM, OUTPUT) and a function returning the acc_w signed maximum, signed minimum and unsigned maximum.
- **Sub-module `sat_add`:** combinational, parameterized on acc_w.
  - Inputs: accumulator, extended addend, mode.
  - Outputs: saturated sum and an overflow bit.
  - `mul_acc_stage` instantiates it once and keeps the FSM, counter and registers.

## Test plan
All scenarios use n = 8, acc_w = 18, len_w = 4.
- **Signed small frame:** mode signed, `frame_len` = 3, products 0xFFF0, 0x0020, 0xFFFF → `acc` = 0x0000F, `acc_sat` = 0, `acc_valid` high 1 cycle after the 3rd accept.
- **Unsigned small frame:** same products in unsigned mode → `acc` = 0x2000F (131087), `acc_sat` = 0.
- **Signed positive saturation:** `frame_len` = 9, each product 0x4000 → `acc` = 0x1FFFF, `acc_sat` = 1.
- **Unsigned saturation:** `frame_len` = 5, each product 0xFE01 → `acc` = 0x3FFFF, `acc_sat` = 1.
- **Stalls and ignored start:**
  - Hold `acc_ready` = 0 for 3 cycles in OUTPUT → `acc` and `acc_valid` stay stable.
  - Pulse `start` during those cycles → ignored.
  - Insert `prod_valid` gaps during ACCUM → the counter does not advance.
- **Reset and zero-length frame:**
  - Drive `rst_n` low after 2 of 5 products → IDLE, `acc` = 0, no `acc_valid`.
  - Then start a frame with `frame_len` = 0 → `acc_valid` with `acc` = 0 on the next cycle.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// ---------------------------------------------------------------------------
// mul_acc_pkg
//
// Shared types and helpers for the multiplier frame accumulator.
//
//   state_t     : accumulator FSM state encoding (IDLE, ACCUM, OUTPUT)
//   sat_lim_t   : the three saturation rails for a given accumulator width
//   sat_limits  : builds the rails for any width up to LIM_W bits
// ---------------------------------------------------------------------------
package mul_acc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   // Widest accumulator the limit helper can describe.
   localparam int LIM_W = 64;

   // Rails are carried in a fixed wide container; callers keep the low
   // acc_w bits. smin holds only the bit pattern of -2^(w-1) within w bits
   // (a single 1 in bit w-1), which is what the low slice needs.
   typedef struct packed {
      logic [LIM_W-1:0] smax;
      logic [LIM_W-1:0] smin;
      logic [LIM_W-1:0] umax;
   } sat_lim_t;

   function automatic sat_lim_t sat_limits(input int unsigned w);
      sat_lim_t lim;
      lim.smax = (64'd1 << (w - 1)) - 64'd1;
      lim.smin = 64'd1 << (w - 1);
      if (w >= 64) begin
         lim.umax = '1;
      end else begin
         lim.umax = (64'd1 << w) - 64'd1;
      end
      return lim;
   endfunction

endpackage

// File: rtl/mul_acc_stage_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
//
// Combinational saturating adder for the frame accumulator.
//
// Parameters:
//   acc_w       accumulator width
// Ports:
//   a           in   acc_w  current accumulator value
//   b           in   acc_w  addend, already extended to acc_w bits
//   signed_mode in   1      1 = two's complement rails, 0 = unsigned rail
//   sum         out  acc_w  saturated result
//   ovf         out  1      the raw sum left the representable range
// ---------------------------------------------------------------------------
module sat_add
   import mul_acc_pkg::*;
#(
   parameter int acc_w = 18
) (
   input  logic [acc_w-1:0] a,
   input  logic [acc_w-1:0] b,
   input  logic             signed_mode,
   output logic [acc_w-1:0] sum,
   output logic             ovf
);

   localparam sat_lim_t LIM = sat_limits(acc_w);

   localparam logic [acc_w-1:0] SMAX = LIM.smax[acc_w-1:0];
   localparam logic [acc_w-1:0] SMIN = LIM.smin[acc_w-1:0];
   localparam logic [acc_w-1:0] UMAX = LIM.umax[acc_w-1:0];

   logic             a_top;
   logic             b_top;
   logic [acc_w:0]   wide_sum;

   // One guard bit: a copy of the sign in signed mode, zero in unsigned mode.
   // The guard then carries either the true sign or the carry-out.
   assign a_top    = signed_mode & a[acc_w-1];
   assign b_top    = signed_mode & b[acc_w-1];
   assign wide_sum = {a_top, a} + {b_top, b};

   always_comb begin
      sum = wide_sum[acc_w-1:0];
      ovf = 1'b0;
      if (signed_mode) begin
         // Guard and MSB disagree exactly when two same-sign addends
         // produced a result of the other sign; the guard gives the true sign.
         if (wide_sum[acc_w] != wide_sum[acc_w-1]) begin
            ovf = 1'b1;
            sum = wide_sum[acc_w] ? SMIN : SMAX;
         end
      end else begin
         if (wide_sum[acc_w]) begin
            ovf = 1'b1;
            sum = UMAX;
         end
      end
   end

endmodule

// File: rtl/mul_acc_stage.sv
// ---------------------------------------------------------------------------
// mul_acc_stage
//
// Frame accumulator behind the multiplier. A frame is requested with a
// one-cycle start pulse carrying its length and signed/unsigned mode; the
// stage then accepts that many 2n-bit products over a valid/ready handshake,
// sums them into a saturating acc_w-bit accumulator, and offers the total
// over a second valid/ready handshake.
//
// Parameters:
//   n           multiplier operand width (products are 2n bits)
//   len_w       frame length field width (frames of 0 .. 2^len_w-1 products)
//   acc_w       accumulator width, at least 2n+1
// Ports:
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      frame request, honoured only in IDLE
//   frame_len   in   len_w  product count, sampled with start
//   signed_mul  in   1      frame mode, sampled with start
//   prod_valid  in   1      product available
//   prod_ready  out  1      product accepted this cycle when valid
//   prod        in   2n     product
//   acc_valid   out  1      frame total available
//   acc_ready   in   1      consumer takes the total
//   acc         out  acc_w  frame total
//   acc_sat     out  1      saturation happened somewhere in this frame
//   busy        out  1      stage is not IDLE
// ---------------------------------------------------------------------------
module mul_acc_stage
   import mul_acc_pkg::*;
#(
   parameter int n     = 8,
   parameter int len_w = 4,
   parameter int acc_w = 2 * n + 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [len_w-1:0]   frame_len,
   input  logic               signed_mul,
   input  logic               prod_valid,
   output logic               prod_ready,
   input  logic [2*n-1:0]     prod,
   output logic               acc_valid,
   input  logic               acc_ready,
   output logic [acc_w-1:0]   acc,
   output logic               acc_sat,
   output logic               busy
);

   localparam logic [len_w-1:0] CNT_ONE = len_w'(1);

   state_t             state_reg;
   logic [len_w-1:0]   cnt_reg;
   logic [acc_w-1:0]   acc_reg;
   logic               sat_reg;
   logic               mode_reg;

   logic [acc_w-1:0]   prod_ext;
   logic [acc_w-1:0]   sum_next;
   logic               ovf_next;
   logic               accept;

   // Widen the product: low 2n bits pass through, the upper bits carry the
   // product sign in signed frames and zero in unsigned frames.
   for (genvar gi = 0; gi < acc_w; gi++) begin : g_ext
      if (gi < 2 * n) begin : g_low
         assign prod_ext[gi] = prod[gi];
      end else begin : g_high
         assign prod_ext[gi] = mode_reg & prod[2*n-1];
      end
   end

   sat_add #(
      .acc_w       (acc_w)
   ) u_sat_add (
      .a           (acc_reg),
      .b           (prod_ext),
      .signed_mode (mode_reg),
      .sum         (sum_next),
      .ovf         (ovf_next)
   );

   // Handshake outputs depend on the state register alone, so nothing from
   // the input ports reaches them combinationally.
   assign prod_ready = (state_reg == ACCUM);
   assign acc_valid  = (state_reg == OUTPUT);
   assign busy       = (state_reg != IDLE);
   assign acc        = acc_reg;
   assign acc_sat    = sat_reg;

   assign accept     = prod_valid && (state_reg == ACCUM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         acc_reg   <= '0;
         sat_reg   <= 1'b0;
         mode_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  acc_reg  <= '0;
                  sat_reg  <= 1'b0;
                  mode_reg <= signed_mul;
                  if (frame_len != '0) begin
                     cnt_reg   <= frame_len;
                     state_reg <= ACCUM;
                  end else begin
                     // Empty frame: report the cleared total straight away.
                     state_reg <= OUTPUT;
                  end
               end
            end

            ACCUM: begin
               if (accept) begin
                  acc_reg <= sum_next;
                  // Sticky: a later opposite-sign product may pull the value
                  // off the rail, but the frame is still flagged.
                  if (ovf_next) begin
                     sat_reg <= 1'b1;
                  end
                  cnt_reg <= cnt_reg - CNT_ONE;
                  if (cnt_reg == CNT_ONE) begin
                     state_reg <= OUTPUT;
                  end
               end
            end

            OUTPUT: begin
               // acc_reg and sat_reg are untouched here, so the result holds
               // for as long as the consumer stalls.
               if (acc_ready) begin
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
